mem_cnt_responder: RTL and testbench
====================================

# mem_cnt_responder

Synthesizable memory-side responder for the packed count-port protocol, with one companion read port for observing counter state. It owns a WORDS×DW counter array, applies `ct_imm` to the addressed word on every accepted `cnt`, and returns `ct_vld`/`ct_serr`/`ct_derr` after LATENCY cycles. The read port returns `dout`/`read_vld` on the same LATENCY. It sits where the behavioural memory model sits in the stitched bench, and is driven by the same count-port and read-port interfaces.

## Interface
- AW, 13, address width
- DW, 32, counter/data width
- WORDS, 8192, number of counters (≤ 2^AW)
- LATENCY, 2, request-to-response cycles (≥ 1)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- ready  out  1  high once init-clear done
- cnt  in  1  count request
- ct_adr  in  AW  counter address
- ct_imm  in  DW  increment value (unsigned)
- ct_vld  out  1  count completion pulse
- ct_serr  out  1  overflow/saturation flag, qualified by ct_vld
- ct_derr  out  1  out-of-range address flag, qualified by ct_vld
- read  in  1  read request
- addr  in  AW  read address
- dout  out  DW  counter value, qualified by read_vld
- read_vld  out  1  read completion pulse
- read_serr  out  1  tied 0
- read_derr  out  1  out-of-range read flag, qualified by read_vld

## Operation
- Reset value of every output is 0.
- FSM states:
  - INIT:
    - Entered on reset.
    - Clears one word per cycle, address 0..WORDS-1.
    - `ready`=0.
    - `cnt`/`read` are ignored: no update, no response.
  - RUN:
    - Entered after the last word is cleared.
    - `ready`=1.
    - Stays in RUN until the next reset.
- Count, when `cnt`=1 in RUN and `ct_adr`<WORDS:
  - new = old + `ct_imm`, computed at DW+1 bits.
  - Written to storage at the clock edge ending the issue cycle.
  - `ct_serr` = carry out of DW.
- Out-of-range count (`ct_adr`≥WORDS): no write; `ct_derr`=1, `ct_serr`=0.
- Back-to-back counts to the same address accumulate exactly, with no lost update.
- Read, when `read`=1 in RUN:
  - Samples storage during the issue cycle, before any same-cycle count commits. A same-cycle count to the same address is therefore not visible to that read.
  - Out-of-range read: `dout`=0, `read_derr`=1.
- `dout` is 0 whenever `read_vld`=0.
- Count and read pipelines are independent: both ports may issue every cycle with no backpressure.

## Timing
- Issue in cycle N produces a response pulse in cycle N+LATENCY: `ct_vld`+flags for counts, `read_vld`+`dout`+flags for reads. Each pulse lasts one cycle.
- Throughput is one count plus one read per cycle.
- `ready` rises WORDS cycles after `rst` deasserts. A request in the same cycle `ready` first reads 1 is accepted.
- Reset asserted mid-operation:
  - All in-flight responses are discarded; no late `ct_vld`/`read_vld`.
  - Outputs go to 0 asynchronously.
  - INIT restarts from address 0 on deassert.
- Counter at 2^DW−1 plus `ct_imm`=1:
  - Wrap build: result 0.
  - Saturate build: result stays 2^DW−1.
  - Both builds: `ct_serr`=1.
- `ct_imm`=0 is legal: storage unchanged, `ct_vld` still returned, `ct_serr`=0.

## Configuration
- `MEM_CNT_SAT_EN` defined: saturating counters.
  - On carry out, the stored result is clamped to all-ones.
  - `ct_serr`=1 whenever clamping occurred.
- `MEM_CNT_SAT_EN` undefined: modulo-2^DW wrap.
  - `ct_serr`=1 on carry out.
  - The stored value is the low DW bits of the sum.

## Test plan
- Init:
  - Stimulus: release `rst`, default params.
  - Required: `ready`=0 for 8192 cycles, then 1.
  - Required: `read` addr 100 → `dout`=0 with `read_vld` 2 cycles later.
  - Required: a `cnt` issued during INIT produces no `ct_vld`.
- Basic count:
  - Stimulus: `cnt` addr 5 imm 7, then `read` addr 5 next cycle.
  - Required: `ct_vld` at N+2 with serr=derr=0.
  - Required: `dout`=7.
- Back-to-back accumulate:
  - Stimulus: four consecutive `cnt` to addr 9 with imm 1, 2, 3, 4, then `read` addr 9.
  - Required: four `ct_vld` pulses; `dout`=10.
- Same-cycle read/count:
  - Stimulus: addr 3 holds 20; issue `cnt` imm 5 and `read` addr 3 in the same cycle; read again next cycle.
  - Required: first `dout`=20, second `dout`=25.
- Overflow:
  - Stimulus: load addr 1 to 0xFFFF_FFFF, then `cnt` imm 2, then read.
  - Required: `ct_serr`=1.
  - Required: `dout`=1 without `MEM_CNT_SAT_EN`, 0xFFFF_FFFF with it.
- Error and reset paths:
  - Stimulus, out-of-range: with WORDS=6000, `cnt` and `read` at addr 7000.
  - Required: `ct_derr`=1, `read_derr`=1, `dout`=0, no storage change.
  - Stimulus, reset mid-flight: assert `rst` one cycle after a `cnt`.
  - Required: no `ct_vld`; after INIT, that address reads 0.

Source files
------------

// File: rtl/mem_cnt_responder_if.sv
// Count-port and read-port bundle between a requester (master) and the counter memory (slave).
interface mem_cnt_responder_if #(
    parameter int AW = 13,
    parameter int DW = 32
);
    logic          ready;
    logic          cnt;
    logic [AW-1:0] ct_adr;
    logic [DW-1:0] ct_imm;
    logic          ct_vld;
    logic          ct_serr;
    logic          ct_derr;
    logic          read;
    logic [AW-1:0] addr;
    logic [DW-1:0] dout;
    logic          read_vld;
    logic          read_serr;
    logic          read_derr;

    modport slave (
        input  cnt, ct_adr, ct_imm, read, addr,
        output ready, ct_vld, ct_serr, ct_derr, dout, read_vld, read_serr, read_derr
    );

    modport master (
        output cnt, ct_adr, ct_imm, read, addr,
        input  ready, ct_vld, ct_serr, ct_derr, dout, read_vld, read_serr, read_derr
    );
endinterface

// File: rtl/mem_cnt_responder.sv
// Counter-memory responder: clears WORDS counters after reset, then serves one count and one read per cycle.
// Optional build macro MEM_CNT_SAT_EN selects saturating counters instead of modulo wrap.
module mem_cnt_responder #(
    parameter int AW      = 13,
    parameter int DW      = 32,
    parameter int WORDS   = 8192,
    parameter int LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    mem_cnt_responder_if.slave bus
);
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic          ct_vld;
        logic          ct_serr;
        logic          ct_derr;
        logic          rd_vld;
        logic          rd_derr;
        logic [DW-1:0] dout;
    } stage_t;

    state_t        state_q, state_d;
    logic [AW-1:0] clr_adr_q, clr_adr_d;
    logic          clr_last;

    // Combinational read ports: the count read-modify-write must finish inside the issue cycle.
    logic [DW-1:0] mem [WORDS];
    logic          mem_we;
    logic [AW-1:0] mem_wadr;
    logic [DW-1:0] mem_wdata;

    logic          run;
    logic          ct_acc;
    logic          ct_in_rng;
    logic          rd_acc;
    logic          rd_in_rng;
    logic [DW:0]   ct_sum;
    logic          ct_carry;
    logic [DW-1:0] ct_new;

    stage_t        issue_s;
    stage_t        pipe_d [LATENCY];
    stage_t        pipe_q [LATENCY];

    assign run       = (state_q == ST_RUN);
    assign clr_last  = (32'(clr_adr_q) == WORDS - 1);
    assign ct_acc    = bus.cnt && run;
    assign rd_acc    = bus.read && run;
    assign ct_in_rng = (32'(bus.ct_adr) < WORDS);
    assign rd_in_rng = (32'(bus.addr) < WORDS);

    always_comb begin
        ct_sum   = {1'b0, mem[bus.ct_adr]} + {1'b0, bus.ct_imm};
        ct_carry = ct_sum[DW];
`ifdef MEM_CNT_SAT_EN
        ct_new   = ct_carry ? {DW{1'b1}} : ct_sum[DW-1:0];
`else
        ct_new   = ct_sum[DW-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_INIT;
            clr_adr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_adr_q <= clr_adr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_adr_d = clr_adr_q;
        mem_we    = 1'b0;
        mem_wadr  = clr_adr_q;
        mem_wdata = '0;
        case (state_q)
            ST_INIT: begin
                mem_we = 1'b1;
                if (clr_last) begin
                    state_d = ST_RUN;
                end else begin
                    clr_adr_d = clr_adr_q + AW'(1);
                end
            end
            ST_RUN: begin
                if (ct_acc && ct_in_rng) begin
                    mem_we    = 1'b1;
                    mem_wadr  = bus.ct_adr;
                    mem_wdata = ct_new;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wadr] <= mem_wdata;
        end
    end

    // Read data is taken before this cycle's count write lands, so a same-cycle count is invisible.
    always_comb begin
        issue_s         = '0;
        issue_s.ct_vld  = ct_acc;
        issue_s.ct_serr = ct_acc && ct_in_rng && ct_carry;
        issue_s.ct_derr = ct_acc && !ct_in_rng;
        issue_s.rd_vld  = rd_acc;
        issue_s.rd_derr = rd_acc && !rd_in_rng;
        issue_s.dout    = (rd_acc && rd_in_rng) ? mem[bus.addr] : '0;
    end

    generate
        for (genvar gi = 0; gi < LATENCY; gi++) begin : g_pipe
            if (gi == 0) begin : g_first
                assign pipe_d[gi] = issue_s;
            end else begin : g_next
                assign pipe_d[gi] = pipe_q[gi-1];
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pipe_q[gi] <= '0;
                end else begin
                    pipe_q[gi] <= pipe_d[gi];
                end
            end
        end
    endgenerate

    assign bus.ready     = run;
    assign bus.ct_vld    = pipe_q[LATENCY-1].ct_vld;
    assign bus.ct_serr   = pipe_q[LATENCY-1].ct_serr;
    assign bus.ct_derr   = pipe_q[LATENCY-1].ct_derr;
    assign bus.read_vld  = pipe_q[LATENCY-1].rd_vld;
    assign bus.read_derr = pipe_q[LATENCY-1].rd_derr;
    assign bus.dout      = pipe_q[LATENCY-1].dout;
    assign bus.read_serr = 1'b0;
endmodule

// File: tb/tb_mem_cnt_responder.sv
// Scoreboard bench for mem_cnt_responder: a counter-array reference model predicts every response.
module tb_mem_cnt_responder;
    localparam int AW      = 13;
    localparam int DW      = 32;
    localparam int WORDS   = 6000;
    localparam int LATENCY = 2;
    localparam longint unsigned MAXV = (64'd1 << DW) - 64'd1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_cnt_responder_if #(.AW(AW), .DW(DW)) bus ();

    mem_cnt_responder #(
        .AW(AW), .DW(DW), .WORDS(WORDS), .LATENCY(LATENCY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int            cyc;
        int            adr;
        logic          serr;
        logic          derr;
        logic [DW-1:0] dout;
    } rsp_t;

    rsp_t          ct_q[$];
    rsp_t          rd_q[$];
    rsp_t          mon_e;
    logic [DW-1:0] ref_mem [WORDS];
    int            cyc      = 0;
    int            rel_cyc  = -1;
    int            checks   = 0;
    int            failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // The memory accepts requests once WORDS cycles have elapsed since reset release.
    function automatic bit in_run();
        return rst && (rel_cyc >= 0) && ((cyc - rel_cyc) >= WORDS);
    endfunction

    // Apply one cycle of stimulus and let the reference model predict the responses.
    task automatic issue(input logic c, input int ca, input logic [DW-1:0] imm,
                         input logic r, input int ra);
        rsp_t e;
        longint unsigned s;
        @(posedge clk);
        #1;
        bus.cnt    = c;
        bus.ct_adr = AW'(ca);
        bus.ct_imm = imm;
        bus.read   = r;
        bus.addr   = AW'(ra);
        if (in_run()) begin
            if (r) begin
                e.cyc  = cyc + LATENCY;
                e.adr  = ra;
                e.serr = 1'b0;
                e.derr = (ra >= WORDS);
                e.dout = '0;
                if (ra < WORDS) e.dout = ref_mem[ra];
                rd_q.push_back(e);
            end
            if (c) begin
                e.cyc  = cyc + LATENCY;
                e.adr  = ca;
                e.dout = '0;
                e.derr = (ca >= WORDS);
                e.serr = 1'b0;
                if (ca < WORDS) begin
                    s = longint'(ref_mem[ca]) + longint'(imm);
                    e.serr = (s > MAXV);
`ifdef MEM_CNT_SAT_EN
                    if (s > MAXV) s = MAXV;
`else
                    s = s % (MAXV + 64'd1);
`endif
                    ref_mem[ca] = DW'(s);
                end
                ct_q.push_back(e);
            end
        end
    endtask

    task automatic idle();
        issue(1'b0, 0, '0, 1'b0, 0);
    endtask

    task automatic assert_reset();
        @(posedge clk);
        #1;
        rst        = 1'b0;
        rel_cyc    = -1;
        bus.cnt    = 1'b0;
        bus.read   = 1'b0;
        ct_q.delete();
        rd_q.delete();
        foreach (ref_mem[i]) ref_mem[i] = '0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst     = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic wait_ready();
        while ((cyc + 1 - rel_cyc) < WORDS) idle();
    endtask

    // Monitor: checks ready/idle outputs every cycle and pops the scoreboard on each response pulse.
    always @(negedge clk) begin
        chk1("ready", bus.ready, in_run());
        while (ct_q.size() > 0 && ct_q[0].cyc < cyc) begin
            chk1("ct_vld_missing", 1'b0, 1'b1);
            void'(ct_q.pop_front());
        end
        while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
            chk1("read_vld_missing", 1'b0, 1'b1);
            void'(rd_q.pop_front());
        end
        if (bus.ct_vld) begin
            if (ct_q.size() == 0) begin
                chk1("ct_vld_unexpected", 1'b1, 1'b0);
            end else begin
                mon_e = ct_q.pop_front();
                chkw("ct_cycle", cyc, mon_e.cyc);
                chk1("ct_serr", bus.ct_serr, mon_e.serr);
                chk1("ct_derr", bus.ct_derr, mon_e.derr);
                $display("ct  rsp cyc=%0d adr=%0d serr=%0b derr=%0b", cyc, mon_e.adr,
                         bus.ct_serr, bus.ct_derr);
            end
        end
        if (bus.read_vld) begin
            if (rd_q.size() == 0) begin
                chk1("read_vld_unexpected", 1'b1, 1'b0);
            end else begin
                mon_e = rd_q.pop_front();
                chkw("rd_cycle", cyc, mon_e.cyc);
                chkw("dout", bus.dout, mon_e.dout);
                chk1("read_derr", bus.read_derr, mon_e.derr);
                chk1("read_serr", bus.read_serr, 1'b0);
                $display("rd  rsp cyc=%0d adr=%0d dout=%0h derr=%0b", cyc, mon_e.adr,
                         bus.dout, bus.read_derr);
            end
        end else begin
            chkw("dout_idle", bus.dout, '0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ca, ra, sel;
        logic [DW-1:0] imm;
        bus.cnt    = 1'b0;
        bus.ct_adr = '0;
        bus.ct_imm = '0;
        bus.read   = 1'b0;
        bus.addr   = '0;
        foreach (ref_mem[i]) ref_mem[i] = '0;
        repeat (3) idle();
        release_reset();

        // A count during init must be ignored entirely.
        repeat (10) idle();
        issue(1'b1, 5, 32'd3, 1'b1, 5);
        idle();
        wait_ready();
        issue(1'b0, 0, '0, 1'b1, 100);

        issue(1'b1, 5, 32'd7, 1'b0, 0);
        issue(1'b0, 0, '0, 1'b1, 5);

        issue(1'b1, 9, 32'd1, 1'b0, 0);
        issue(1'b1, 9, 32'd2, 1'b0, 0);
        issue(1'b1, 9, 32'd3, 1'b0, 0);
        issue(1'b1, 9, 32'd4, 1'b0, 0);
        issue(1'b0, 0, '0, 1'b1, 9);

        issue(1'b1, 3, 32'd20, 1'b0, 0);
        issue(1'b1, 3, 32'd5, 1'b1, 3);
        issue(1'b0, 0, '0, 1'b1, 3);

        issue(1'b1, 1, 32'hFFFF_FFFF, 1'b0, 0);
        issue(1'b1, 1, 32'd2, 1'b0, 0);
        issue(1'b0, 0, '0, 1'b1, 1);

        issue(1'b1, 9, 32'd0, 1'b1, 9);
        issue(1'b1, 7000, 32'd5, 1'b1, 7000);
        issue(1'b1, WORDS - 1, 32'd11, 1'b1, WORDS);
        issue(1'b0, 0, '0, 1'b1, WORDS - 1);

        for (int n = 0; n < 3000; n++) begin
            sel = int'($urandom_range(0, 19));
            ca  = (sel == 0) ? int'($urandom_range(WORDS, (1 << AW) - 1)) :
                  (sel == 1) ? WORDS - 1 : (sel == 2) ? WORDS : int'($urandom_range(0, 15));
            ra  = (sel == 3) ? int'($urandom_range(WORDS, (1 << AW) - 1)) : int'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       imm = '0;
                1:       imm = DW'($urandom_range(1, 100));
                2:       imm = 32'hFFFF_FF00 + DW'($urandom_range(0, 255));
                default: imm = DW'($urandom);
            endcase
            issue(1'($urandom_range(0, 1)), ca, imm, 1'($urandom_range(0, 1)), ra);
        end
        repeat (4) idle();

        // Reset one cycle after a count: the response is dropped and init clears the word.
        issue(1'b1, 12, 32'd9, 1'b0, 0);
        assert_reset();
        repeat (3) idle();
        release_reset();
        wait_ready();
        issue(1'b0, 0, '0, 1'b1, 12);
        issue(1'b0, 0, '0, 1'b1, 5);
        repeat (6) idle();

        chkw("ct_q_drained", ct_q.size(), 0);
        chkw("rd_q_drained", rd_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
